branch_pc_unit: RTL and testbench

- Next-PC and branch-resolution stage that sits directly downstream of branch_comp.
- Consumes BrEq/BrLT together with the branch funct3, and drives BrUn back to the comparator.
- Decides taken/not-taken, holds the architectural PC register, redirects fetch, and issues a timed pipeline flush.
- Traps misaligned control-flow targets: no compressed extension, so targets must be 4-byte aligned.

---
 rtl/branch_pc_unit.sv | 214 +++++++++++++++++++++
 tb/tb_branch_pc_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: branch resolution, architectural PC register, fetch redirect
// with a timed flush pulse, and misaligned control-flow target trap.
// Optional build macro BRANCH_STATS_EN adds saturating counters of
// taken / not-taken conditional branches plus a synchronous clear input.
module branch_pc_unit #(
    parameter int unsigned    n            = 32,
    parameter logic [n-1:0]   RESET_VEC    = 32'h0000_0000,
    parameter logic [n-1:0]   TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned    FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         is_branch,
    input  logic         is_jal,
    input  logic         is_jalr,
    input  logic [2:0]   funct3,
    input  logic         BrEq,
    input  logic         BrLT,
    output logic         BrUn,
    input  logic [n-1:0] target,
    input  logic         trap_ack,
    output logic [n-1:0] pc,
    output logic [n-1:0] pc_plus4,
    output logic         flush,
    output logic         misaligned
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]  br_taken_cnt,
    output logic [31:0]  br_nottaken_cnt,
    input  logic         stats_clr
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_TRAP  = 2'b10
    } state_e;

    // Counter is loaded with FLUSH_CYCLES-1 so that flush spans FLUSH_CYCLES
    // non-stalled cycles including the redirect cycle itself.
    localparam logic [3:0]   FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [n-1:0] PC_STEP    = {{(n-3){1'b0}}, 3'b100};

    state_e       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic         flush_q, flush_d;
    logic         mis_q, mis_d;
    logic [3:0]   cnt_q, cnt_d;

    logic         br_taken_s;
    logic         taken_s;
    logic [n-1:0] eff_target_s;
    logic         target_misaligned_s;
    logic [n-1:0] pc_plus4_s;

    // Unsigned compare for BLTU/BGEU (and the unused 010/011 encodings).
    assign BrUn       = funct3[1];
    assign pc_plus4_s = pc_q + PC_STEP;
    assign pc_plus4   = pc_plus4_s;
    assign pc         = pc_q;
    assign flush      = flush_q;
    assign misaligned = mis_q;

    // Conditional-branch outcome from the comparator flags.
    always_comb begin
        br_taken_s = 1'b0;
        case (funct3)
            3'b000:          br_taken_s = BrEq;
            3'b001:          br_taken_s = ~BrEq;
            3'b100, 3'b110:  br_taken_s = BrLT;
            3'b101, 3'b111:  br_taken_s = ~BrLT;
            default:         br_taken_s = 1'b0;
        endcase
    end

    // Redirect decision and effective target; JAL wins over JALR over branch.
    always_comb begin
        taken_s      = 1'b0;
        eff_target_s = target;
        if (is_jal) begin
            taken_s      = 1'b1;
            eff_target_s = target;
        end else if (is_jalr) begin
            taken_s      = 1'b1;
            eff_target_s = {target[n-1:1], 1'b0};
        end else if (is_branch) begin
            taken_s      = br_taken_s;
            eff_target_s = target;
        end else begin
            taken_s      = 1'b0;
            eff_target_s = target;
        end
        target_misaligned_s = (eff_target_s[1:0] != 2'b00);
    end

    // Next-state logic for the RUN / FLUSH / TRAP controller and PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush_d = flush_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (taken_s) begin
                    if (target_misaligned_s) begin
                        mis_d   = 1'b1;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d    = eff_target_s;
                        flush_d = 1'b1;
                        cnt_d   = FLUSH_LOAD;
                        state_d = ST_FLUSH;
                    end
                end else begin
                    pc_d = pc_plus4_s;
                end
            end
            ST_FLUSH: begin
                if (stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_plus4_s;
                    if (cnt_q == 4'd0) begin
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            ST_TRAP: begin
                // Stall is deliberately ignored: only the handler ack moves us on.
                if (trap_ack) begin
                    pc_d    = TRAP_VEC;
                    mis_d   = 1'b0;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_VEC;
                flush_d = 1'b0;
                mis_d   = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Controller state, PC and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            flush_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flush_q <= flush_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;
    logic [31:0] nt_cnt_q, nt_cnt_d;
    logic        count_s;

    // Only resolved conditional branches count; jumps take precedence over is_branch.
    always_comb begin
        count_s     = (state_q == ST_RUN) && !stall && is_branch && !is_jal && !is_jalr;
        taken_cnt_d = taken_cnt_q;
        nt_cnt_d    = nt_cnt_q;
        if (stats_clr) begin
            taken_cnt_d = 32'd0;
            nt_cnt_d    = 32'd0;
        end else if (count_s) begin
            if (br_taken_s) begin
                taken_cnt_d = (taken_cnt_q == 32'hFFFF_FFFF) ? taken_cnt_q : taken_cnt_q + 32'd1;
            end else begin
                nt_cnt_d = (nt_cnt_q == 32'hFFFF_FFFF) ? nt_cnt_q : nt_cnt_q + 32'd1;
            end
        end else begin
            taken_cnt_d = taken_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q <= 32'd0;
            nt_cnt_q    <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            nt_cnt_q    <= nt_cnt_d;
        end
    end

    assign br_taken_cnt    = taken_cnt_q;
    assign br_nottaken_cnt = nt_cnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed steps from the test plan
// followed by randomized traffic, all checked against a behavioural model
// that decides branches from the compared operand values themselves.
module tb_branch_pc_unit;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam int          FC        = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, is_branch, is_jal, is_jalr, trap_ack;
    logic [2:0]  funct3;
    logic        BrEq, BrLT, BrUn;
    logic [31:0] target, pc, pc_plus4;
    logic        flush, misaligned;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_taken_cnt, br_nottaken_cnt;
    logic        stats_clr;
`endif

    // Operands the (modelled) branch comparator is looking at.
    logic [31:0] opa, opb;

    // Reference model state.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_trap;
    logic [31:0] m_taken_cnt, m_nt_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(
        .n(32), .RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .FLUSH_CYCLES(FC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .is_branch(is_branch),
        .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3), .BrEq(BrEq),
        .BrLT(BrLT), .BrUn(BrUn), .target(target), .trap_ack(trap_ack),
        .pc(pc), .pc_plus4(pc_plus4), .flush(flush), .misaligned(misaligned)
`ifdef BRANCH_STATS_EN
        , .br_taken_cnt(br_taken_cnt), .br_nottaken_cnt(br_nottaken_cnt),
        .stats_clr(stats_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural branch semantics on the raw operands.
    function automatic bit branch_outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc         = RESET_VEC;
        m_flush_left = 0;
        m_trap       = 1'b0;
        m_taken_cnt  = 32'd0;
        m_nt_cnt     = 32'd0;
    endtask

    task automatic model_edge();
        bit          jump, cond, outcome, taken;
        logic [31:0] dest;
        jump    = is_jal || is_jalr;
        cond    = is_branch && !jump;
        outcome = branch_outcome(funct3, opa, opb);
        if (m_trap) begin
            if (trap_ack) begin
                m_pc         = TRAP_VEC;
                m_trap       = 1'b0;
                m_flush_left = FC;
            end
        end else if (m_flush_left > 0) begin
            if (!stall) begin
                m_pc = m_pc + 32'd4;
                m_flush_left--;
            end
        end else if (!stall) begin
            taken = jump || (cond && outcome);
            dest  = is_jal ? target : (is_jalr ? (target & 32'hFFFF_FFFE) : target);
            if (cond) begin
                if (outcome) m_taken_cnt = (m_taken_cnt == 32'hFFFF_FFFF) ? m_taken_cnt : m_taken_cnt + 32'd1;
                else         m_nt_cnt    = (m_nt_cnt == 32'hFFFF_FFFF) ? m_nt_cnt : m_nt_cnt + 32'd1;
            end
            if (taken) begin
                if (dest % 4 != 0) m_trap = 1'b1;
                else begin
                    m_pc         = dest;
                    m_flush_left = FC;
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
`ifdef BRANCH_STATS_EN
        if (stats_clr) begin
            m_taken_cnt = 32'd0;
            m_nt_cnt    = 32'd0;
        end
`endif
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pc"}, pc, m_pc);
        check({tag, "_flush"}, {31'd0, flush}, (m_flush_left > 0) ? 32'd1 : 32'd0);
        check({tag, "_misaligned"}, {31'd0, misaligned}, {31'd0, m_trap});
`ifdef BRANCH_STATS_EN
        check({tag, "_taken_cnt"}, br_taken_cnt, m_taken_cnt);
        check({tag, "_nottaken_cnt"}, br_nottaken_cnt, m_nt_cnt);
`endif
    endtask

    // One clock: comparator flags from operands, combinational checks, edge, registered checks.
    task automatic step(input string tag);
        BrEq = (opa == opb);
        BrLT = funct3[1] ? (opa < opb) : ($signed(opa) < $signed(opb));
        #1;
        check({tag, "_brun"}, {31'd0, BrUn}, {31'd0, funct3[1]});
        check({tag, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);
        @(posedge clk);
        model_edge();
        #1;
        check_state(tag);
    endtask

    task automatic idle();
        stall = 0; is_branch = 0; is_jal = 0; is_jalr = 0; trap_ack = 0;
        funct3 = 3'b000; opa = 32'd0; opb = 32'd1; target = 32'd0;
`ifdef BRANCH_STATS_EN
        stats_clr = 0;
`endif
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        check({tag, "_pc_const"}, pc, RESET_VEC);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] vals [4];
        vals[0] = 32'h0000_0000; vals[1] = 32'h0000_0001;
        vals[2] = 32'h8000_0000; vals[3] = 32'hFFFF_FFFF;

        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Three idle cycles from reset.
        for (int i = 0; i < 3; i++) step("idle");
        check("idle3_pc", pc, 32'h0000_000C);
        step("idle");

        // BEQ taken from pc 0x10.
        is_branch = 1; funct3 = 3'b000; opa = 32'd7; opb = 32'd7; target = 32'h40;
        step("beq");
        check("beq_pc", pc, 32'h40);
        idle();
        step("beq_f1");
        check("beq_f1_flush", {31'd0, flush}, 32'd1);
        step("beq_f2");
        check("beq_f2_pc", pc, 32'h48);
        check("beq_f2_flush", {31'd0, flush}, 32'd0);

        // BGEU with a < b unsigned: not taken.
        is_branch = 1; funct3 = 3'b111; opa = 32'd1; opb = 32'd2; target = 32'h80;
        step("bgeu");
        check("bgeu_pc", pc, 32'h4C);

        // BLT signed vs BLTU on the same operands.
        is_branch = 1; funct3 = 3'b100; opa = 32'hFFFF_FFFF; opb = 32'd1; target = 32'h60;
        step("blt");
        idle(); step("blt_f1"); step("blt_f2");
        is_branch = 1; funct3 = 3'b110; opa = 32'hFFFF_FFFF; opb = 32'd1; target = 32'h90;
        step("bltu");
        is_branch = 1; funct3 = 3'b010; opa = 32'd3; opb = 32'd3; target = 32'hA0;
        step("illegal_f3");

        // JALR clears bit 0.
        idle(); is_jalr = 1; target = 32'h0000_0205;
        step("jalr");
        check("jalr_pc", pc, 32'h204);
        idle(); step("jalr_f1"); step("jalr_f2");

        // JALR misaligned: trap holds through stall toggling.
        is_jalr = 1; target = 32'h0000_0206;
        step("jalr_mis");
        idle();
        for (int i = 0; i < 4; i++) begin
            stall = i[0];
            step("trap_hold");
        end
        stall = 0; trap_ack = 1;
        step("trap_ack");
        check("trap_ack_pc", pc, 32'h100);
        idle(); step("trap_f1"); step("trap_f2");

        // JAL with priority over JALR and branch, then stall stretches flush.
        is_jal = 1; is_jalr = 1; is_branch = 1; funct3 = 3'b000; opa = 32'd1; opb = 32'd1;
        target = 32'h300;
        step("jal_prio");
        check("jal_prio_pc", pc, 32'h300);
        idle(); stall = 1;
        for (int i = 0; i < 3; i++) step("flush_stall");
        check("flush_stall_pc", pc, 32'h300);
        stall = 0;
        step("flush_s4");
        check("flush_s4_flush", {31'd0, flush}, 32'd1);
        step("flush_s5");
        check("flush_s5_flush", {31'd0, flush}, 32'd0);

        // PC wrap in RUN.
        is_jal = 1; target = 32'hFFFF_FFF4;
        step("wrap_jal");
        idle(); step("wrap_f1"); step("wrap_f2");
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        step("wrap");
        check("wrap_pc", pc, 32'h0);

        // Reset mid-flush and mid-trap leaves nothing pending.
        is_jal = 1; target = 32'h40;
        step("pre_rst_flush");
        idle();
        async_reset("rst_flush");
        step("post_rst_flush");
        is_jalr = 1; target = 32'h43;
        step("pre_rst_trap");
        idle();
        async_reset("rst_trap");
        step("post_rst_trap");

`ifdef BRANCH_STATS_EN
        // Two taken and one not-taken branch, then clear.
        stats_clr = 1; step("stats_clr0"); idle();
        is_branch = 1; funct3 = 3'b000; opa = 32'd5; opb = 32'd5; target = 32'h200;
        step("stats_b1"); idle(); step("stats_w1"); step("stats_w2");
        is_branch = 1; funct3 = 3'b001; opa = 32'd5; opb = 32'd6; target = 32'h300;
        step("stats_b2"); idle(); step("stats_w3"); step("stats_w4");
        is_branch = 1; funct3 = 3'b101; opa = 32'hFFFF_FFFF; opb = 32'd0; target = 32'h400;
        step("stats_b3"); idle();
        check("stats_taken_2", br_taken_cnt, 32'd2);
        check("stats_nottaken_1", br_nottaken_cnt, 32'd1);
        stats_clr = 1; step("stats_clr"); idle();
        check("stats_clr_taken", br_taken_cnt, 32'd0);
        check("stats_clr_nottaken", br_nottaken_cnt, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 4) == 0);
            is_branch = ($urandom_range(0, 1) == 1);
            is_jal    = ($urandom_range(0, 7) == 0);
            is_jalr   = ($urandom_range(0, 7) == 0);
            funct3    = 3'($urandom_range(0, 7));
            opa       = vals[$urandom_range(0, 3)];
            opb       = vals[$urandom_range(0, 3)];
            target    = $urandom;
            if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
            trap_ack  = ($urandom_range(0, 2) == 0);
`ifdef BRANCH_STATS_EN
            stats_clr = ($urandom_range(0, 49) == 0);
`endif
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
